updown_sweep_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 4-bit asynchronous up/down counter: it drives the counter's clear, toggle-enable `t` and `up_down` inputs so the counter sweeps lo→hi→lo for a programmed number of passes, then signals completion. It keeps a shadow position and compares it against the counter's `q` every active cycle, raising a sticky mismatch flag on divergence. Start/busy/done handshake toward the test/control logic above it.

---
 rtl/updown_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : updown_sweep_ctrl                                          |
// | Brief   : Drives clear/step/direction of a WIDTH-bit up/down counter |
// |           so it sweeps lo->hi->lo for npass passes, tracks a shadow  |
// |           position and flags any divergence of the counter output.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module updown_sweep_ctrl #(
   parameter int WIDTH  = 4,
   parameter int PASS_W = 4
) (
   input  logic              clk,
   input  logic              rst,      // active-low, asynchronous
   input  logic              start,
   input  logic              abort,
   input  logic [WIDTH-1:0]  lo,
   input  logic [WIDTH-1:0]  hi,
   input  logic [PASS_W-1:0] npass,
   input  logic [WIDTH-1:0]  q,
   output logic              clr,
   output logic              t,
   output logic              up_down,
   output logic [WIDTH-1:0]  pos,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mism
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_PRE  = 3'd2,
      S_UP   = 3'd3,
      S_DOWN = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [WIDTH-1:0]   lo_r;
   logic [WIDTH-1:0]   hi_r;
   logic [PASS_W-1:0]  npass_r;
   logic [PASS_W-1:0]  pass_cnt;
   logic [PASS_W-1:0]  pass_inc;
   logic [WIDTH-1:0]   pos_step;
   logic               start_ok;
   logic               accept;
   logic               stepping;
   logic               checking;

   // Request qualification, shadow-position lookahead and pass increment.
   always_comb begin
      start_ok = (lo < hi) && (npass != '0);
      accept   = (state == S_IDLE) && start && start_ok;
      stepping = (state == S_PRE) || (state == S_UP) || (state == S_DOWN);
      checking = stepping || (state == S_DONE);
      // Direction is derived from the state, not from up_down, to keep the
      // lookahead independent of the output decode below.
      pos_step = (state == S_DOWN) ? (pos - WIDTH'(1)) : (pos + WIDTH'(1));
      pass_inc = pass_cnt + PASS_W'(1);
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic and Moore output decode. Transitions look at the
   // position the counter will hold after this edge (pos_step).
   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      t         = 1'b0;
      up_down   = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = S_CLR;
         end
         S_CLR: begin
            clr  = 1'b1;
            busy = 1'b1;
            if (abort)             state_nxt = S_IDLE;
            else if (lo_r != '0)   state_nxt = S_PRE;
            else                   state_nxt = S_UP;
         end
         S_PRE: begin
            t    = 1'b1;
            busy = 1'b1;
            if (abort)                 state_nxt = S_IDLE;
            else if (pos_step == lo_r) state_nxt = S_UP;
         end
         S_UP: begin
            t    = 1'b1;
            busy = 1'b1;
            if (abort)                 state_nxt = S_IDLE;
            else if (pos_step == hi_r) state_nxt = S_DOWN;
         end
         S_DOWN: begin
            t       = 1'b1;
            up_down = 1'b0;
            busy    = 1'b1;
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (pos_step == lo_r) begin
               if (pass_inc == npass_r) state_nxt = S_DONE;
               else                     state_nxt = S_UP;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Sweep parameters, shadow position, pass count, error pulse and the
   // sticky mismatch flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lo_r     <= '0;
         hi_r     <= '0;
         npass_r  <= '0;
         pass_cnt <= '0;
         pos      <= '0;
         err      <= 1'b0;
         mism     <= 1'b0;
      end else begin
         err <= (state == S_IDLE) && start && !start_ok;

         if (accept) begin
            lo_r     <= lo;
            hi_r     <= hi;
            npass_r  <= npass;
            pass_cnt <= '0;
            mism     <= 1'b0;
         end else if (checking && (q != pos)) begin
            mism <= 1'b1;
         end

         // An abort freezes the shadow position where it stands.
         if (!abort) begin
            if (state == S_CLR)  pos <= '0;
            else if (stepping)   pos <= pos_step;
         end

         if ((state == S_DOWN) && !abort && (pos_step == lo_r))
            pass_cnt <= pass_inc;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_updown_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_updown_sweep_ctrl                                       |
// | Brief   : Directed bench for updown_sweep_ctrl with a behavioural    |
// |           4-bit up/down counter closing the loop on q.               |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_updown_sweep_ctrl;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] lo    = 4'd0;
   logic [3:0] hi    = 4'd0;
   logic [3:0] npass = 4'd0;
   logic [3:0] q;
   logic       clr, t, up_down, busy, done, err, mism;
   logic [3:0] pos;

   logic [3:0] cq;
   logic       skip  = 1'b0;
   int         total = 0;
   int         bad   = 0;

   updown_sweep_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .lo(lo), .hi(hi), .npass(npass), .q(q),
      .clr(clr), .t(t), .up_down(up_down), .pos(pos),
      .busy(busy), .done(done), .err(err), .mism(mism)
   );

   always #5 clk = ~clk;

   // Counter model; skip makes it jump two steps on one up edge.
   always @(posedge clk or negedge rst) begin
      if (!rst)        cq <= 4'd0;
      else if (clr)    cq <= 4'd0;
      else if (t)      cq <= up_down ? (cq + (skip ? 4'd2 : 4'd1)) : (cq - 4'd1);
   end
   assign q = cq;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a start for one edge; returns in cycle E+1.
   task automatic launch(input logic [3:0] l, input logic [3:0] h, input logic [3:0] n);
      lo = l; hi = h; npass = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({clr, t, up_down, busy, done, err, mism} !== 7'b0010000 || pos !== 4'd0) begin
         bad++;
         $display("FAIL reset_state: got clr%b t%b ud%b busy%b done%b err%b mism%b pos%0d want 0 0 1 0 0 0 0 pos0",
                  clr, t, up_down, busy, done, err, mism, pos);
      end
      #10 rst = 1'b1;
      tick();
      // Reset in the middle of an up ramp.
      launch(4'd2, 4'd5, 4'd1);
      repeat (4) tick();
      total++;
      if (busy !== 1'b1 || pos !== 4'd3 || up_down !== 1'b1 || t !== 1'b1) begin
         bad++;
         $display("FAIL reset_pre: got busy%b pos%0d ud%b t%b want busy1 pos3 ud1 t1", busy, pos, up_down, t);
      end
      #3 rst = 1'b0;
      #1;
      total++;
      if ({clr, t, up_down, busy, done, err, mism} !== 7'b0010000 || pos !== 4'd0) begin
         bad++;
         $display("FAIL reset_async: got clr%b t%b ud%b busy%b done%b err%b mism%b pos%0d want 0 0 1 0 0 0 0 pos0",
                  clr, t, up_down, busy, done, err, mism, pos);
      end
      #1 rst = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || t !== 1'b0 || done !== 1'b0 || pos !== 4'd0) begin
         bad++;
         $display("FAIL reset_release: got busy%b t%b done%b pos%0d want 0 0 0 0", busy, t, done, pos);
      end
   endtask

   task automatic test_single_pass();
      logic [3:0] ep [9];
      logic       et [9];
      logic       eud[9];
      ep  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
      et  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      eud = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      launch(4'd2, 4'd5, 4'd1);
      total++;
      if (clr !== 1'b1 || t !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL single_clr: got clr%b t%b busy%b done%b want 1 0 1 0", clr, t, busy, done);
      end
      for (int k = 0; k < 9; k++) begin
         tick();
         total++;
         if (pos !== ep[k] || t !== et[k] || up_down !== eud[k] || clr !== 1'b0 ||
             done !== (k == 8) || busy !== 1'b1 || mism !== 1'b0) begin
            bad++;
            $display("FAIL single_cyc%0d: got pos%0d t%b ud%b clr%b done%b busy%b mism%b want pos%0d t%b ud%b clr0 done%b busy1 mism0",
                     k + 2, pos, t, up_down, clr, done, busy, mism, ep[k], et[k], eud[k], (k == 8));
         end
      end
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL single_end: got busy%b done%b want 0 0", busy, done);
      end
   endtask

   task automatic test_lo_zero();
      logic [3:0] ep [13];
      logic       eud[13];
      ep  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
      eud = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      launch(4'd0, 4'd3, 4'd2);
      total++;
      if (clr !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL lo0_clr: got clr%b busy%b want 1 1", clr, busy);
      end
      for (int k = 0; k < 13; k++) begin
         tick();
         total++;
         if (pos !== ep[k] || up_down !== eud[k] || t !== (k != 12) || done !== (k == 12)) begin
            bad++;
            $display("FAIL lo0_cyc%0d: got pos%0d ud%b t%b done%b want pos%0d ud%b t%b done%b",
                     k + 2, pos, up_down, t, done, ep[k], eud[k], (k != 12), (k == 12));
         end
      end
      tick();
   endtask

   task automatic test_reject();
      launch(4'd7, 4'd7, 4'd1);
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || clr !== 1'b0) begin
         bad++;
         $display("FAIL rej_lohi: got err%b busy%b clr%b want 1 0 0", err, busy, clr);
      end
      tick();
      total++;
      if (err !== 1'b0 || busy !== 1'b0 || clr !== 1'b0) begin
         bad++;
         $display("FAIL rej_lohi_after: got err%b busy%b clr%b want 0 0 0", err, busy, clr);
      end
      launch(4'd1, 4'd4, 4'd0);
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || clr !== 1'b0) begin
         bad++;
         $display("FAIL rej_npass: got err%b busy%b clr%b want 1 0 0", err, busy, clr);
      end
      tick();
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rej_npass_after: got err%b busy%b want 0 0", err, busy);
      end
   endtask

   task automatic test_abort();
      launch(4'd1, 4'd6, 4'd1);
      repeat (9) tick();
      total++;
      if (pos !== 4'd4 || up_down !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_pre: got pos%0d ud%b busy%b want pos4 ud0 busy1", pos, up_down, busy);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || t !== 1'b0 || pos !== 4'd4 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_idle: got busy%b t%b pos%0d done%b want 0 0 pos4 0", busy, t, pos, done);
      end
      tick();
      total++;
      if (pos !== 4'd4 || done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_hold: got pos%0d done%b busy%b want pos4 0 0", pos, done, busy);
      end
      // Fresh sweep after the abort: 1 + 0 + 2*2 + 1 = 6 cycles to done.
      launch(4'd0, 4'd2, 4'd1);
      repeat (5) tick();
      total++;
      if (done !== 1'b1 || mism !== 1'b0 || pos !== 4'd0) begin
         bad++;
         $display("FAIL abort_restart: got done%b mism%b pos%0d want 1 0 pos0", done, mism, pos);
      end
      tick();
   endtask

   task automatic test_mismatch();
      launch(4'd1, 4'd3, 4'd1);
      tick();
      tick();
      skip = 1'b1;
      tick();
      skip = 1'b0;
      total++;
      if (mism !== 1'b0 || pos !== 4'd2) begin
         bad++;
         $display("FAIL mism_early: got mism%b pos%0d want 0 pos2", mism, pos);
      end
      tick();
      total++;
      if (mism !== 1'b1) begin
         bad++;
         $display("FAIL mism_set: got mism%b want 1", mism);
      end
      repeat (2) tick();
      total++;
      if (done !== 1'b1 || mism !== 1'b1) begin
         bad++;
         $display("FAIL mism_sticky: got done%b mism%b want 1 1", done, mism);
      end
      tick();
      launch(4'd2, 4'd5, 4'd1);
      total++;
      if (mism !== 1'b0 || clr !== 1'b1) begin
         bad++;
         $display("FAIL mism_clear: got mism%b clr%b want 0 1", mism, clr);
      end
      repeat (9) tick();
      total++;
      if (done !== 1'b1 || mism !== 1'b0) begin
         bad++;
         $display("FAIL mism_clean_run: got done%b mism%b want 1 0", done, mism);
      end
      tick();
   endtask

   task automatic test_start_while_busy();
      launch(4'd0, 4'd2, 4'd1);
      start = 1'b1; lo = 4'd9; hi = 4'd9;
      tick();
      start = 1'b0;
      total++;
      if (err !== 1'b0 || busy !== 1'b1 || clr !== 1'b0) begin
         bad++;
         $display("FAIL busy_start: got err%b busy%b clr%b want 0 1 0", err, busy, clr);
      end
      repeat (4) tick();
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL busy_done: got done%b want 1", done);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_lo_zero();
      test_reject();
      test_abort();
      test_mismatch();
      test_start_while_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
